// File: rtl/dcache_wt.sv
// Direct-mapped, write-through, no-write-allocate data cache with a req/ready word memory port.
// Optional hit/miss counters are built when DCACHE_STATS_EN is defined.
module dcache_wt #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 17,
  parameter int SETS       = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] A,
  input  logic                  RE,
  input  logic                  WE,
  input  logic [2:0]            AddressingControl,
  input  logic [DATA_WIDTH-1:0] WD,
  output logic [DATA_WIDTH-1:0] RD,
  output logic                  stall,
  output logic                  misaligned,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [2:0]            mem_ctrl,
  output logic [DATA_WIDTH-1:0] mem_wd,
  input  logic                  mem_ready,
  input  logic [DATA_WIDTH-1:0] mem_rd
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]           hit_count,
  output logic [31:0]           miss_count
`endif
);

  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = ADDR_WIDTH - 2 - IDX_W;

  typedef enum logic [2:0] {IDLE, FETCH, FILL, WRITE, DONE} state_t;

  state_t                  state, state_next;
  logic [SETS-1:0]         valid;
  logic [TAG_W-1:0]        tag_mem  [SETS];
  logic [DATA_WIDTH-1:0]   data_mem [SETS];
  logic [DATA_WIDTH-1:0]   fill_word;
  logic [IDX_W-1:0]        index;
  logic [TAG_W-1:0]        tag;
  logic [1:0]              offset;
  logic                    hit;
  logic                    addr_bad;
  logic                    unused_a;

  assign index    = A[2 +: IDX_W];
  assign tag      = A[ADDR_WIDTH-1 -: TAG_W];
  assign offset   = A[1:0];
  assign hit      = valid[index] && (tag_mem[index] == tag);
  assign addr_bad = ((AddressingControl[1:0] == 2'b01) && A[0]) ||
                    (AddressingControl[1] && (A[1:0] != 2'b00));
  assign unused_a = ^A[DATA_WIDTH-1:ADDR_WIDTH];

  function automatic logic [31:0] load_ext(input logic [31:0] word, input logic [1:0] off,
                                           input logic [2:0] ctrl);
    logic [7:0]  b;
    logic [15:0] h;
    case (off)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = off[1] ? word[31:16] : word[15:0];
    case (ctrl[1:0])
      2'b00:   load_ext = ctrl[2] ? {24'd0, b} : {{24{b[7]}}, b};
      2'b01:   load_ext = ctrl[2] ? {16'd0, h} : {{16{h[15]}}, h};
      default: load_ext = word;
    endcase
  endfunction

  function automatic logic [31:0] store_merge(input logic [31:0] word, input logic [31:0] wd,
                                              input logic [1:0] off, input logic [2:0] ctrl);
    logic [31:0] m;
    m = word;
    case (ctrl[1:0])
      2'b00: begin
        case (off)
          2'd0:    m[7:0]   = wd[7:0];
          2'd1:    m[15:8]  = wd[7:0];
          2'd2:    m[23:16] = wd[7:0];
          default: m[31:24] = wd[7:0];
        endcase
      end
      2'b01: begin
        if (off[1]) m[31:16] = wd[15:0];
        else        m[15:0]  = wd[15:0];
      end
      default: m = wd;
    endcase
    return m;
  endfunction

  // State register; reset abandons any request in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next state and all CPU/memory outputs; everything is quiet while rst is high.
  always_comb begin
    state_next = state;
    stall      = 1'b0;
    misaligned = 1'b0;
    RD         = '0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_ctrl   = 3'b000;
    mem_wd     = '0;
    if (!rst) begin
      case (state)
        IDLE: begin
          if ((RE || WE) && addr_bad) begin
            misaligned = 1'b1;
          end else if (WE) begin
            stall      = 1'b1;
            state_next = WRITE;
          end else if (RE && hit) begin
            RD = load_ext(data_mem[index], offset, AddressingControl);
          end else if (RE) begin
            stall      = 1'b1;
            state_next = FETCH;
          end else begin
            state_next = IDLE;
          end
        end
        FETCH: begin
          mem_req    = 1'b1;
          mem_addr   = {A[ADDR_WIDTH-1:2], 2'b00};
          mem_ctrl   = 3'b010;
          stall      = 1'b1;
          state_next = mem_ready ? FILL : FETCH;
        end
        FILL: begin
          RD         = load_ext(fill_word, offset, AddressingControl);
          state_next = IDLE;
        end
        WRITE: begin
          mem_req    = 1'b1;
          mem_we     = 1'b1;
          mem_addr   = A[ADDR_WIDTH-1:0];
          mem_ctrl   = AddressingControl;
          mem_wd     = WD;
          stall      = 1'b1;
          state_next = mem_ready ? DONE : WRITE;
        end
        DONE:    state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end else begin
      state_next = IDLE;
    end
  end

  // Valid bits are the only reset storage, so a line becomes visible only once FILL commits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                valid        <= '0;
    else if (state == FILL) valid[index] <= 1'b1;
    else                    valid        <= valid;
  end

  // Line storage, fill capture and store-hit merge.
  always_ff @(posedge clk) begin
    if (state == FETCH && mem_ready) fill_word <= mem_rd;
    if (state == FILL) begin
      tag_mem[index]  <= tag;
      data_mem[index] <= fill_word;
    end else if (state == WRITE && mem_ready && hit) begin
      data_mem[index] <= store_merge(data_mem[index], WD, offset, AddressingControl);
    end
  end

`ifdef DCACHE_STATS_EN
  // Saturating hit/miss counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_count  <= 32'd0;
      miss_count <= 32'd0;
    end else begin
      if (state == IDLE && RE && !WE && !addr_bad && hit && hit_count != 32'hFFFF_FFFF)
        hit_count <= hit_count + 32'd1;
      if (state == IDLE && state_next == FETCH && miss_count != 32'hFFFF_FFFF)
        miss_count <= miss_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dcache_wt.sv
// Randomized bench for dcache_wt: a word-memory model plus a line-residency model
// predict every cache response; the bench itself plays the data memory.
module tb_dcache_wt;
  localparam int SETS = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] A;
  logic        RE, WE;
  logic [2:0]  AddressingControl;
  logic [31:0] WD, RD;
  logic        stall, misaligned, mem_req, mem_we, mem_ready;
  logic [16:0] mem_addr;
  logic [2:0]  mem_ctrl;
  logic [31:0] mem_wd, mem_rd;
`ifdef DCACHE_STATS_EN
  logic [31:0] hit_count, miss_count;
`endif

  dcache_wt dut (
    .clk(clk), .rst(rst), .A(A), .RE(RE), .WE(WE), .AddressingControl(AddressingControl),
    .WD(WD), .RD(RD), .stall(stall), .misaligned(misaligned), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_ctrl(mem_ctrl), .mem_wd(mem_wd),
    .mem_ready(mem_ready), .mem_rd(mem_rd)
`ifdef DCACHE_STATS_EN
    , .hit_count(hit_count), .miss_count(miss_count)
`endif
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] mem_model [int];
  bit          line_valid [SETS];
  int          line_widx  [SETS];
  int          exp_hits   = 0;
  int          exp_misses = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_read(input int widx);
    if (mem_model.exists(widx)) return mem_model[widx];
    return (widx * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  function automatic logic [31:0] extend(input logic [31:0] word, input int off, input logic [2:0] ctrl);
    logic [31:0] v;
    v = word >> (8 * off);
    if (ctrl[1:0] == 2'b00) begin
      v = v & 32'h0000_00FF;
      if (!ctrl[2] && v[7]) v = v | 32'hFFFF_FF00;
    end else if (ctrl[1:0] == 2'b01) begin
      v = v & 32'h0000_FFFF;
      if (!ctrl[2] && v[15]) v = v | 32'hFFFF_0000;
    end else begin
      v = word;
    end
    return v;
  endfunction

  function automatic void mem_write(input int widx, input int off, input logic [2:0] ctrl,
                                    input logic [31:0] wd);
    logic [31:0] w;
    w = mem_read(widx);
    if (ctrl[1:0] == 2'b00)      w[8*off +: 8]  = wd[7:0];
    else if (ctrl[1:0] == 2'b01) w[8*off +: 16] = wd[15:0];
    else                         w = wd;
    mem_model[widx] = w;
  endfunction

  // One CPU access from IDLE back to IDLE; wait_n extra cycles before mem_ready.
  task automatic access(input logic re, input logic we, input logic [16:0] addr,
                        input logic [2:0] ctrl, input logic [31:0] wd, input int wait_n,
                        output logic [31:0] rd_seen, output logic missed);
    int          widx, set, off;
    logic        mis, hit, busy;
    logic [31:0] word, exp_rd;
    logic [14:0] hi;
    widx   = int'(addr >> 2);
    set    = widx % SETS;
    off    = int'(addr[1:0]);
    mis    = (re || we) && (((ctrl[1:0] == 2'b01) && addr[0]) || (ctrl[1] && addr[1:0] != 2'b00));
    hit    = line_valid[set] && (line_widx[set] == widx);
    word   = mem_read(widx);
    exp_rd = extend(word, off, ctrl);
    hi     = 15'($urandom);
    A = {hi, addr}; RE = re; WE = we; AddressingControl = ctrl; WD = wd; mem_ready = 1'b0;
    @(negedge clk);
    rd_seen = RD;
    missed  = stall;
    busy    = !mis && (we || (re && !hit));
    check("misaligned", {31'd0, misaligned}, {31'd0, mis});
    check("idle_req", {31'd0, mem_req}, 32'd0);
    check("idle_stall", {31'd0, stall}, {31'd0, busy});
    if (mis || (!re && !we)) check("quiet_rd", RD, 32'd0);
    else if (!we && hit) begin
      check("hit_rd", RD, exp_rd);
      exp_hits++;
    end
    if (busy) begin
      if (!we) exp_misses++;
      for (int k = 0; k <= wait_n; k++) begin
        @(posedge clk); #1;
        mem_ready = (k == wait_n);
        mem_rd    = we ? $urandom : word;
        @(negedge clk);
        check("bus_req", {31'd0, mem_req}, 32'd1);
        check("bus_we", {31'd0, mem_we}, {31'd0, we});
        check("bus_stall", {31'd0, stall}, 32'd1);
        check("bus_addr", {15'd0, mem_addr}, we ? {15'd0, addr} : {15'd0, addr[16:2], 2'b00});
        check("bus_ctrl", {29'd0, mem_ctrl}, we ? {29'd0, ctrl} : 32'd2);
        if (we) check("bus_wd", mem_wd, wd);
      end
      @(posedge clk); #1;
      mem_ready = 1'b0;
      mem_rd    = $urandom;
      @(negedge clk);
      check("end_stall", {31'd0, stall}, 32'd0);
      check("end_req", {31'd0, mem_req}, 32'd0);
      if (!we) begin
        check("fill_rd", RD, exp_rd);
        rd_seen         = RD;
        line_valid[set] = 1'b1;
        line_widx[set]  = widx;
      end else begin
        mem_write(widx, off, ctrl, wd);
      end
    end
    @(posedge clk); #1;
    RE = 1'b0; WE = 1'b0;
  endtask

  logic [31:0] rd;
  logic        missed;

  initial begin
    rst = 1'b1; A = 32'd0; RE = 1'b0; WE = 1'b0; AddressingControl = 3'b000;
    WD = 32'd0; mem_ready = 1'b0; mem_rd = 32'd0;
    foreach (line_valid[i]) line_valid[i] = 1'b0;
    @(negedge clk);
    check("rst_stall", {31'd0, stall}, 32'd0);
    check("rst_req", {31'd0, mem_req}, 32'd0);
    check("rst_addr", {15'd0, mem_addr}, 32'd0);
    check("rst_rd", RD, 32'd0);
    check("rst_mis", {31'd0, misaligned}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    mem_model[32'h10000 >> 2] = 32'hDEAD_BEEF;
    access(1'b1, 1'b0, 17'h10000, 3'b010, 32'd0, 0, rd, missed);
    check("plan_fill", rd, 32'hDEAD_BEEF);
    check("plan_first_miss", {31'd0, missed}, 32'd1);
    access(1'b1, 1'b0, 17'h10000, 3'b010, 32'd0, 0, rd, missed);
    check("plan_rehit", {31'd0, missed}, 32'd0);
    access(1'b1, 1'b0, 17'h10003, 3'b000, 32'd0, 0, rd, missed);
    check("plan_lb", rd, 32'hFFFF_FFDE);
    access(1'b1, 1'b0, 17'h10003, 3'b100, 32'd0, 0, rd, missed);
    check("plan_lbu", rd, 32'h0000_00DE);
    access(1'b1, 1'b0, 17'h10002, 3'b001, 32'd0, 0, rd, missed);
    check("plan_lh", rd, 32'hFFFF_DEAD);
    access(1'b1, 1'b0, 17'h10002, 3'b101, 32'd0, 0, rd, missed);
    check("plan_lhu", rd, 32'h0000_DEAD);
    access(1'b0, 1'b1, 17'h10001, 3'b000, 32'h0000_0055, 2, rd, missed);
    access(1'b1, 1'b0, 17'h10000, 3'b010, 32'd0, 0, rd, missed);
    check("plan_sb_hit", rd, 32'hDEAD_55EF);
    check("plan_sb_hit_nomiss", {31'd0, missed}, 32'd0);
    access(1'b0, 1'b1, 17'h10100, 3'b010, 32'h1234_5678, 1, rd, missed);
    access(1'b1, 1'b0, 17'h10100, 3'b010, 32'd0, 1, rd, missed);
    check("plan_noalloc_miss", {31'd0, missed}, 32'd1);
    check("plan_noalloc_rd", rd, 32'h1234_5678);
    access(1'b1, 1'b0, 17'h10000, 3'b010, 32'd0, 0, rd, missed);
    check("plan_evict_miss", {31'd0, missed}, 32'd1);
    access(1'b1, 1'b0, 17'h10002, 3'b010, 32'd0, 0, rd, missed);
    check("plan_mis_nostall", {31'd0, missed}, 32'd0);

    // Reset in the middle of a fetch.
    A = 32'h0001_0200; RE = 1'b1; WE = 1'b0; AddressingControl = 3'b010;
    @(posedge clk); #2;
    check("pre_rst_req", {31'd0, mem_req}, 32'd1);
    rst = 1'b1;
    #1;
    check("async_req", {31'd0, mem_req}, 32'd0);
    check("async_stall", {31'd0, stall}, 32'd0);
    check("async_addr", {15'd0, mem_addr}, 32'd0);
    mem_ready = 1'b1;
    mem_rd    = 32'hBAD0_BAD0;
    @(posedge clk); #1;
    mem_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    RE  = 1'b0;
    foreach (line_valid[i]) line_valid[i] = 1'b0;
    exp_hits   = 0;
    exp_misses = 0;
    @(posedge clk); #1;
    access(1'b1, 1'b0, 17'h10200, 3'b010, 32'd0, 0, rd, missed);
    check("post_rst_miss", {31'd0, missed}, 32'd1);
    access(1'b1, 1'b0, 17'h10000, 3'b010, 32'd0, 0, rd, missed);
    check("post_rst_miss2", {31'd0, missed}, 32'd1);

    for (int n = 0; n < 300; n++) begin
      int          kind, t, s, o, c;
      logic [2:0]  ctrl_tab [6];
      logic [16:0] a;
      ctrl_tab = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b110};
      kind = $urandom_range(0, 9);
      t    = $urandom_range(0, 3);
      s    = $urandom_range(0, 7);
      o    = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 3) : 0;
      c    = $urandom_range(0, 5);
      a    = 17'(((t << 6) | s) << 2) | 17'(o);
      access(kind < 5 || kind == 8, kind >= 5 && kind <= 8, a, ctrl_tab[c], $urandom,
             $urandom_range(0, 3), rd, missed);
    end

`ifdef DCACHE_STATS_EN
    check("hit_count", hit_count, exp_hits);
    check("miss_count", miss_count, exp_misses);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
